sc_sng_bank: RTL
================

Name: sc_sng_bank

Overview:
- Multi-channel stochastic number generator (SNG) bank for the SC FIR datapath.
- One shared cycle counter drives a per-channel low-discrepancy sequence: plain count, van der Corput (bit-reversed count), or scrambled VDC (bit-reversed count XOR a per-channel key).
- Each channel compares its latched binary operand against its sequence value and emits one stochastic bit per accepted cycle.
- A start/done FSM with valid/ready backpressure frames exactly one full period of 2^WIDTH bits.

Parameters:
- WIDTH, 12, bit width of operands, sequence values and counter; stream length is 2^WIDTH.
- NUM_CH, 4, number of independent channels.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a stream; sampled only in IDLE.
- abort  in  1  terminate a running stream with no done pulse.
- x_in  in  NUM_CH*WIDTH  operands; channel c occupies bits [c*WIDTH +: WIDTH]; latched on accepted start.
- mode_in  in  NUM_CH*2  per-channel mode: 0 COUNT, 1 VDC, 2 SCRAMBLE, 3 reserved (treated as VDC); latched on start.
- key_in  in  NUM_CH*WIDTH  per-channel scramble key; latched on start.
- bit_ready  in  1  consumer accepts the current bits.
- bit_valid  out  1  bits and seq_out are valid.
- bits  out  NUM_CH  stochastic bit per channel.
- seq_out  out  NUM_CH*WIDTH  current sequence value per channel, for debug and correlation checks.
- busy  out  1  high in RUN or DONE.
- done  out  1  one-cycle pulse at stream completion.
- ones_cnt  out  NUM_CH*(WIDTH+1)  number of 1 bits accepted per channel in the current or last stream.

Behaviour:
- Reset:
  - state IDLE; count 0; latched x, mode and key cleared.
  - bit_valid 0, done 0, busy 0, ones_cnt 0.
  - bits and seq_out are computed from the cleared state, so they read 0.
- State IDLE:
  - start=1 latches x_in, mode_in and key_in; count <= 0; ones_cnt <= 0; next state RUN.
- State RUN:
  - bit_valid=1, busy=1.
  - seq[c] = count (COUNT); bitrev(count) (VDC); bitrev(count) ^ key[c] (SCRAMBLE).
  - bits[c] = (x[c] > seq[c]), unsigned compare.
  - bits and seq_out depend only on registered state; no combinational path from any input.
  - Handshake = bit_valid & bit_ready. On handshake: count increments and ones_cnt[c] += bits[c].
  - Handshake while count == 2^WIDTH-1 → state DONE; count wraps to 0.
  - bit_ready=0 holds count, bits and ones_cnt unchanged for any number of cycles.
- State DONE:
  - done=1 for exactly one cycle, bit_valid=0, busy=1; next state IDLE.
  - ones_cnt holds its value until the next accepted start.
- abort:
  - In RUN, abort wins over a same-cycle handshake: next state IDLE, no done, and that cycle's bits are not counted.
  - In IDLE or DONE, abort is ignored.
- start is ignored outside IDLE, including in the DONE cycle.
- Latency:
  - First valid bit appears the cycle after start is accepted.
  - With bit_ready held at 1, done asserts 2^WIDTH+1 cycles after start.
- Arithmetic:
  - Over a full period, every mode visits each value 0..2^WIDTH-1 exactly once, so ones_cnt[c] == x[c] exactly.
  - Range of ones_cnt is 0..2^WIDTH-1; the extra bit keeps the width safe.
- reset mid-stream returns to the reset state on the next edge, whatever the state or handshake.

Decomposition:
- Package sc_pkg:
  - typedef enum logic[1:0] seq_mode_e {SEQ_COUNT, SEQ_VDC, SEQ_SCRAMBLE, SEQ_RSVD}.
  - typedef enum {S_IDLE, S_RUN, S_DONE} sng_state_e.
  - function bitrev parameterised by WIDTH.
- Sub-module sc_seq_map: purely combinational (count, mode, key) → seq; one instance per channel in a generate loop.
- Top module holds the counter, FSM, comparators and ones accumulators.

Test Plan (WIDTH=4, NUM_CH=2 unless noted):
- VDC, x0=5, bit_ready=1 → seq0 = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; bits0 =1 at k=0,2,4,8,12 only; ones_cnt0=5; done at cycle 17 after start.
- COUNT, x1=5 → bits1 = 1 for k=0..4, then 0 for k=5..15; ones_cnt1=5.
- SCRAMBLE, key0=4'hA, x0=9 → seq0[0]=10, seq0[1]=2; ones_cnt0=9. Boundary operands x=0 → 0 ones; x=15 → 15 ones.
- bit_ready toggled 1,0,0,1 repeatedly → count and bits held while ready is low; totals identical to the no-stall run; done only after 16 handshakes.
- abort at k=7 together with ready=1 → IDLE next cycle, no done, ones_cnt reflects k=0..6 only. start during RUN or DONE is ignored. start held high in IDLE → one stream per accepted start.
- reset asserted at k=10 → next cycle all outputs at reset values; a following start runs a clean 16-bit stream.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic number generator bank.
// The bit-reverse helper is width-generic up to BITREV_MAX bits.
package sc_pkg;

   localparam int BITREV_MAX = 32;

   typedef enum logic [1:0] {
      SEQ_COUNT    = 2'd0,
      SEQ_VDC      = 2'd1,
      SEQ_SCRAMBLE = 2'd2,
      SEQ_RSVD     = 2'd3
   } seq_mode_e;

   typedef enum {S_IDLE, S_RUN, S_DONE} sng_state_e;

   // Reverses the low w bits of v; bits at and above w come back as zero.
   function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                    input int w);
      logic [BITREV_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < BITREV_MAX; i++) begin
         if (i < w) r[i] = v[w-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/sc_sng_bank_if.sv
// Stream-control and stochastic-bit bundle between a consumer and the SNG bank.
interface sc_sng_bank_if #(
   parameter int WIDTH  = 12,
   parameter int NUM_CH = 4
);
   logic                        start;
   logic                        abort;
   logic [NUM_CH*WIDTH-1:0]     x_in;
   logic [NUM_CH*2-1:0]         mode_in;
   logic [NUM_CH*WIDTH-1:0]     key_in;
   logic                        bit_ready;
   logic                        bit_valid;
   logic [NUM_CH-1:0]           bits;
   logic [NUM_CH*WIDTH-1:0]     seq_out;
   logic                        busy;
   logic                        done;
   logic [NUM_CH*(WIDTH+1)-1:0] ones_cnt;

   modport master (
      output start, abort, x_in, mode_in, key_in, bit_ready,
      input  bit_valid, bits, seq_out, busy, done, ones_cnt
   );

   modport slave (
      input  start, abort, x_in, mode_in, key_in, bit_ready,
      output bit_valid, bits, seq_out, busy, done, ones_cnt
   );
endinterface

// File: rtl/sc_seq_map.sv
// Maps the shared counter to one channel's low-discrepancy sequence value.
module sc_seq_map
   import sc_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic [WIDTH-1:0] count,
   input  seq_mode_e        mode,
   input  logic [WIDTH-1:0] key,
   output logic [WIDTH-1:0] seq
);

   logic [WIDTH-1:0] rev;

   assign rev = WIDTH'(bitrev(BITREV_MAX'(count), WIDTH));

   // NOTE: the default assignment ahead of the case keeps every path driven, so no latch.
   always_comb begin
      seq = rev;
      case (mode)
         SEQ_COUNT:    seq = count;
         SEQ_SCRAMBLE: seq = rev ^ key;
         default:      seq = rev;
      endcase
   end

endmodule

// File: rtl/sc_sng_bank.sv
// Multi-channel SNG bank: shared counter, per-channel sequence maps and comparators,
// ones accumulators, and a start/run/done FSM framing one 2^WIDTH-bit period.
module sc_sng_bank
   import sc_pkg::*;
#(
   parameter int WIDTH  = 12,
   parameter int NUM_CH = 4
) (
   input logic          clock,
   input logic          reset,
   sc_sng_bank_if.slave bus
);

   localparam logic [WIDTH-1:0] LAST = '1;

   sng_state_e        state, state_nxt;
   logic [WIDTH-1:0]  count;
   logic [WIDTH-1:0]  x_q    [NUM_CH];
   seq_mode_e         mode_q [NUM_CH];
   logic [WIDTH-1:0]  key_q  [NUM_CH];
   logic [WIDTH-1:0]  seq    [NUM_CH];
   logic [WIDTH:0]    ones_q [NUM_CH];
   logic [NUM_CH-1:0] bits_w;
   logic              run;
   logic              take;

   assign run  = (state == S_RUN);
   assign take = run & ~bus.abort & bus.bit_ready;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_RUN;
         S_RUN: begin
            if (bus.abort)                               state_nxt = S_IDLE;
            else if (bus.bit_ready && (count == LAST))   state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.bit_valid = run;
      bus.busy      = (state != S_IDLE);
      bus.done      = (state == S_DONE);
   end

   // NOTE: the operand/mode/key latches are reset too, so bits and seq_out read 0 out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            x_q[c]    <= '0;
            mode_q[c] <= SEQ_COUNT;
            key_q[c]  <= '0;
            ones_q[c] <= '0;
         end
      end else if ((state == S_IDLE) && bus.start) begin
         count <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            x_q[c]    <= bus.x_in[c*WIDTH +: WIDTH];
            mode_q[c] <= seq_mode_e'(bus.mode_in[c*2 +: 2]);
            key_q[c]  <= bus.key_in[c*WIDTH +: WIDTH];
            ones_q[c] <= '0;
         end
      end else if (take) begin
         count <= count + 1'b1;
         for (int c = 0; c < NUM_CH; c++) begin
            ones_q[c] <= ones_q[c] + (WIDTH+1)'(bits_w[c]);
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      sc_seq_map #(.WIDTH(WIDTH)) u_map (
         .count (count),
         .mode  (mode_q[c]),
         .key   (key_q[c]),
         .seq   (seq[c])
      );
      assign bits_w[c]                               = (x_q[c] > seq[c]);
      assign bus.seq_out[c*WIDTH +: WIDTH]           = seq[c];
      assign bus.ones_cnt[c*(WIDTH+1) +: (WIDTH+1)] = ones_q[c];
   end

   assign bus.bits = bits_w;

endmodule
